// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer port arbiter.
package fb_pkg;

    localparam int unsigned FB_ADDR_W = 16;
    localparam int unsigned FB_DATA_W = 8;

    typedef enum logic [1:0] {
        CMD_IDLE    = 2'd0,
        CMD_RD      = 2'd1,
        CMD_WR_HOST = 2'd2,
        CMD_WR_FILL = 2'd3
    } cmd_state_e;

    typedef enum logic {
        REQ_HOST = 1'b0,
        REQ_FILL = 1'b1
    } req_id_e;

endpackage

// File: rtl/fb_port_arbiter_if.sv
// Requester, RAM and status signals of the framebuffer port arbiter.
interface fb_port_arbiter_if
    import fb_pkg::*;
#(
    parameter int unsigned ADDR_W = FB_ADDR_W,
    parameter int unsigned DATA_W = FB_DATA_W
) ();

    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_rvalid;
    logic [DATA_W-1:0] disp_rdata;

    logic              host_req;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_data;
    logic              host_gnt;

    logic              fill_req;
    logic [ADDR_W-1:0] fill_addr;
    logic [DATA_W-1:0] fill_data;
    logic              fill_gnt;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [1:0]        starve;
    logic              starve_clr;

    modport slave (
        input  disp_req, disp_addr, host_req, host_addr, host_data,
               fill_req, fill_addr, fill_data, mem_rdata, starve_clr,
        output disp_rvalid, disp_rdata, host_gnt, fill_gnt,
               mem_en, mem_we, mem_addr, mem_wdata, starve
    );

    modport master (
        output disp_req, disp_addr, host_req, host_addr, host_data,
               fill_req, fill_addr, fill_data, mem_rdata, starve_clr,
        input  disp_rvalid, disp_rdata, host_gnt, fill_gnt,
               mem_en, mem_we, mem_addr, mem_wdata, starve
    );

endinterface

// File: rtl/fb_starve_mon.sv
// Per-writer saturating wait counter with a sticky starvation flag.
module fb_starve_mon #(
    parameter int unsigned STARVE_MAX = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic gnt,
    input  logic clr,
    output logic flag
);

    localparam int unsigned       CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt;
    logic             waiting;
    logic             hit;

    assign waiting = req && !gnt;
    // Set when this cycle's increment lands on (or stays at) the limit.
    assign hit     = waiting && (cnt >= CNT_MAX - CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            flag <= 1'b0;
        end else begin
            if (!waiting)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + CNT_W'(1);

            if (hit)
                flag <= 1'b1;
            else if (clr)
                flag <= 1'b0;
        end
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer arbiter: display reads first, round-robin between
// the host and fill writers, one registered RAM command per cycle.
module fb_port_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned ADDR_W     = FB_ADDR_W,
    parameter int unsigned DATA_W     = FB_DATA_W,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned STARVE_MAX = 64
) (
    input logic               clk,
    input logic               rst,
    fb_port_arbiter_if.slave  bus
);

    cmd_state_e        state, nxt_state;
    req_id_e           rr_last, nxt_rr_last;
    logic [ADDR_W-1:0] nxt_addr;
    logic [DATA_W-1:0] nxt_wdata;
    logic              host_elig, fill_elig;
    logic [RD_LAT-1:0] rd_pipe;
    logic              starve_host, starve_fill;

    // Next command; a writer granted this cycle is masked so its stale req is ignored.
    always_comb begin
        nxt_state   = CMD_IDLE;
        nxt_rr_last = rr_last;
        nxt_addr    = bus.mem_addr;
        nxt_wdata   = bus.mem_wdata;
        host_elig   = bus.host_req && !bus.host_gnt;
        fill_elig   = bus.fill_req && !bus.fill_gnt;

        if (bus.disp_req) begin
            nxt_state = CMD_RD;
            nxt_addr  = bus.disp_addr;
        end else if (host_elig && (!fill_elig || rr_last == REQ_FILL)) begin
            nxt_state   = CMD_WR_HOST;
            nxt_addr    = bus.host_addr;
            nxt_wdata   = bus.host_data;
            nxt_rr_last = REQ_HOST;
        end else if (fill_elig) begin
            nxt_state   = CMD_WR_FILL;
            nxt_addr    = bus.fill_addr;
            nxt_wdata   = bus.fill_data;
            nxt_rr_last = REQ_FILL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= CMD_IDLE;
            rr_last       <= REQ_FILL;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.host_gnt  <= 1'b0;
            bus.fill_gnt  <= 1'b0;
            rd_pipe       <= '0;
        end else begin
            state         <= nxt_state;
            rr_last       <= nxt_rr_last;
            bus.mem_en    <= (nxt_state != CMD_IDLE);
            bus.mem_we    <= (nxt_state == CMD_WR_HOST) || (nxt_state == CMD_WR_FILL);
            bus.mem_addr  <= nxt_addr;
            bus.mem_wdata <= nxt_wdata;
            bus.host_gnt  <= (nxt_state == CMD_WR_HOST);
            bus.fill_gnt  <= (nxt_state == CMD_WR_FILL);
            // Read-return valid tracks the RD command on the pins through the RAM latency.
            rd_pipe[0]    <= (state == CMD_RD);
            for (int i = 1; i < RD_LAT; i++)
                rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    assign bus.disp_rvalid = rd_pipe[RD_LAT-1];
    assign bus.disp_rdata  = bus.disp_rvalid ? bus.mem_rdata : '0;

    fb_starve_mon #(.STARVE_MAX(STARVE_MAX)) u_starve_host (
        .clk  (clk),
        .rst  (rst),
        .req  (bus.host_req),
        .gnt  (bus.host_gnt),
        .clr  (bus.starve_clr),
        .flag (starve_host)
    );

    fb_starve_mon #(.STARVE_MAX(STARVE_MAX)) u_starve_fill (
        .clk  (clk),
        .rst  (rst),
        .req  (bus.fill_req),
        .gnt  (bus.fill_gnt),
        .clr  (bus.starve_clr),
        .flag (starve_fill)
    );

    assign bus.starve = {starve_fill, starve_host};

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter with a one-cycle-latency RAM model.
module tb_fb_port_arbiter;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    int   wr_cnt;
    int   base;
    int   hi;
    int   fi;
    logic exp_v;
    logic [7:0] ram [0:65535];

    fb_port_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

    fb_port_arbiter #(
        .ADDR_W(16), .DATA_W(8), .RD_LAT(1), .STARVE_MAX(64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // RAM model: synchronous write, registered read data (latency 1).
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) begin
            ram[bus.mem_addr] <= bus.mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end else if (bus.mem_en) begin
            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.disp_req   = 1'b0;
        bus.disp_addr  = '0;
        bus.host_req   = 1'b0;
        bus.host_addr  = '0;
        bus.host_data  = '0;
        bus.fill_req   = 1'b0;
        bus.fill_addr  = '0;
        bus.fill_data  = '0;
        bus.starve_clr = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        n_cmp = 0;
        n_bad = 0;
        wr_cnt = 0;
        bus.mem_rdata = '0;
        for (int i = 0; i < 65536; i++) ram[i] = init_val(16'(i));
        clear_inputs();

        // Reset state
        step();
        step();
        check("rst_mem_en", 32'(bus.mem_en), 0);
        check("rst_mem_we", 32'(bus.mem_we), 0);
        check("rst_mem_addr", 32'(bus.mem_addr), 0);
        check("rst_gnts", 32'({bus.host_gnt, bus.fill_gnt}), 0);
        check("rst_rvalid", 32'(bus.disp_rvalid), 0);
        check("rst_starve", 32'(bus.starve), 0);
        rst = 1'b0;
        step();

        // Single host write
        base = wr_cnt;
        bus.host_req = 1'b1; bus.host_addr = 16'h0002; bus.host_data = 8'h03;
        step();
        check("t1_we", 32'(bus.mem_we), 1);
        check("t1_en", 32'(bus.mem_en), 1);
        check("t1_addr", 32'(bus.mem_addr), 32'h0002);
        check("t1_wdata", 32'(bus.mem_wdata), 32'h03);
        check("t1_gnt", 32'(bus.host_gnt), 1);
        bus.host_req = 1'b0;
        step();
        check("t1_gnt_drop", 32'(bus.host_gnt), 0);
        check("t1_en_drop", 32'(bus.mem_en), 0);
        check("t1_addr_hold", 32'(bus.mem_addr), 32'h0002);
        check("t1_wr_count", 32'(wr_cnt - base), 1);
        check("t1_ram", 32'(ram[16'h0002]), 32'h03);

        // Ten back-to-back display reads
        bus.disp_req = 1'b1; bus.disp_addr = 16'h0100;
        for (int s = 1; s <= 14; s++) begin
            step();
            exp_v = (s >= 2 && s <= 11);
            check("t2_rvalid", 32'(bus.disp_rvalid), 32'(exp_v));
            if (exp_v)
                check("t2_rdata", 32'(bus.disp_rdata), 32'(init_val(16'(32'h0100 + s - 2))));
            if (s < 10) bus.disp_addr = 16'(32'h0100 + s);
            else        bus.disp_req  = 1'b0;
        end

        // Both writers held: strict alternation, host first after reset
        do_reset();
        base = wr_cnt;
        hi = 0; fi = 0;
        bus.host_req = 1'b1; bus.host_addr = 16'h0200; bus.host_data = 8'hA0;
        bus.fill_req = 1'b1; bus.fill_addr = 16'h0300; bus.fill_data = 8'hB0;
        for (int s = 1; s <= 8; s++) begin
            step();
            if (s % 2 == 1) begin
                check("t3_host_gnt", 32'({bus.host_gnt, bus.fill_gnt}), 32'b10);
                check("t3_host_addr", 32'(bus.mem_addr), 32'h0200 + 32'(hi));
                check("t3_host_data", 32'(bus.mem_wdata), 32'hA0 + 32'(hi));
                hi++;
                bus.host_addr = 16'(32'h0200 + hi);
                bus.host_data = 8'(32'hA0 + hi);
            end else begin
                check("t3_fill_gnt", 32'({bus.host_gnt, bus.fill_gnt}), 32'b01);
                check("t3_fill_addr", 32'(bus.mem_addr), 32'h0300 + 32'(fi));
                check("t3_fill_data", 32'(bus.mem_wdata), 32'hB0 + 32'(fi));
                fi++;
                bus.fill_addr = 16'(32'h0300 + fi);
                bus.fill_data = 8'(32'hB0 + fi);
            end
        end
        bus.host_req = 1'b0; bus.fill_req = 1'b0;
        step();
        check("t3_idle", 32'(bus.mem_en), 0);
        check("t3_wr_count", 32'(wr_cnt - base), 8);

        // Host starved behind 70 cycles of display reads
        bus.disp_req = 1'b1; bus.disp_addr = 16'h0010;
        bus.host_req = 1'b1; bus.host_addr = 16'h0040; bus.host_data = 8'h77;
        for (int k = 1; k <= 73; k++) begin
            step();
            if (k == 30) check("t4_no_gnt", 32'(bus.host_gnt), 0);
            if (k == 63) check("t4_starve_pre", 32'(bus.starve), 0);
            if (k == 64) check("t4_starve_set", 32'(bus.starve), 32'b01);
            if (k == 70) begin
                check("t4_still_rd", 32'({bus.mem_en, bus.mem_we}), 32'b10);
                bus.disp_req = 1'b0;
            end
            if (k == 71) begin
                check("t4_host_gnt", 32'(bus.host_gnt), 1);
                check("t4_host_we", 32'(bus.mem_we), 1);
                check("t4_host_addr", 32'(bus.mem_addr), 32'h0040);
                check("t4_host_data", 32'(bus.mem_wdata), 32'h77);
                bus.host_req = 1'b0;
            end
            if (k == 72) begin
                check("t4_sticky", 32'(bus.starve), 32'b01);
                bus.starve_clr = 1'b1;
            end
            if (k == 73) begin
                check("t4_cleared", 32'(bus.starve), 0);
                bus.starve_clr = 1'b0;
            end
        end

        // Fill granted while display request arrives; stale fill req not regranted
        base = wr_cnt;
        bus.fill_req = 1'b1; bus.fill_addr = 16'h0050; bus.fill_data = 8'h11;
        step();
        check("t5_fill_gnt", 32'(bus.fill_gnt), 1);
        check("t5_fill_addr", 32'(bus.mem_addr), 32'h0050);
        bus.disp_req = 1'b1; bus.disp_addr = 16'h0060;
        step();
        check("t5_rd_cmd", 32'({bus.mem_en, bus.mem_we}), 32'b10);
        check("t5_rd_addr", 32'(bus.mem_addr), 32'h0060);
        check("t5_no_regrant", 32'(bus.fill_gnt), 0);
        bus.fill_req = 1'b0; bus.disp_req = 1'b0;
        step();
        check("t5_idle", 32'({bus.mem_en, bus.fill_gnt}), 0);
        check("t5_rvalid", 32'(bus.disp_rvalid), 1);
        check("t5_rdata", 32'(bus.disp_rdata), 32'(init_val(16'h0060)));
        check("t5_wr_count", 32'(wr_cnt - base), 1);
        check("t5_ram", 32'(ram[16'h0050]), 32'h11);

        // Asynchronous reset with reads in flight and writers pending
        bus.disp_req = 1'b1; bus.disp_addr = 16'h0100;
        bus.host_req = 1'b1; bus.host_addr = 16'h0070; bus.host_data = 8'h22;
        bus.fill_req = 1'b1; bus.fill_addr = 16'h0080; bus.fill_data = 8'h33;
        step();
        step();
        check("t6_pre_rvalid", 32'(bus.disp_rvalid), 1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_en", 32'({bus.mem_en, bus.mem_we}), 0);
        check("t6_rst_rvalid", 32'(bus.disp_rvalid), 0);
        check("t6_rst_rdata", 32'(bus.disp_rdata), 0);
        check("t6_rst_gnts", 32'({bus.host_gnt, bus.fill_gnt}), 0);
        check("t6_rst_addr", 32'(bus.mem_addr), 0);
        bus.disp_req = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        check("t6_first_gnt", 32'({bus.host_gnt, bus.fill_gnt}), 32'b10);
        check("t6_first_addr", 32'(bus.mem_addr), 32'h0070);
        check("t6_no_rvalid_a", 32'(bus.disp_rvalid), 0);
        bus.host_req = 1'b0;
        step();
        check("t6_second_gnt", 32'({bus.host_gnt, bus.fill_gnt}), 32'b01);
        check("t6_no_rvalid_b", 32'(bus.disp_rvalid), 0);
        bus.fill_req = 1'b0;
        step();
        check("t6_idle", 32'(bus.mem_en), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
